// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory bus between the instruction fetch (IF) port and the
//   load-store (LS) port. It runs one transaction at a time, and LS wins when
//   both ports request in the same cycle. The FSM walks IDLE -> REQ -> WAIT ->
//   RESP and always passes through IDLE once between transactions.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a bus timeout of TIMEOUT_CYC cycles ends a stuck
//     transaction with err=1 and rdata=0.
//     When undefined, transactions wait indefinitely and the err outputs are 0.
//
// Ports
//   clk, rst           core clock (rising edge) / async active-low reset
//   if_req_i/addr_i    fetch request (held until if_valid_o) / address
//   if_rdata_o/valid_o fetch data / one-cycle completion pulse
//   flush_i            discards an in-flight fetch result
//   ls_req_i/we_i/sel_i/addr_i/wdata_i  load-store request and payload
//   ls_rdata_o/valid_o load data / one-cycle completion pulse
//   bus_*_o            registered shared-bus request and payload
//   bus_gnt_i/rvalid_i/rdata_i  bus grant / response valid / read data
//   stallreq_if_o/stallreq_mem_o  pipeline stall requests
//   if_err_o/ls_err_o  timeout error, pulsed with the matching valid
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_valid_o,
   input  logic        flush_i,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_sel_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic [31:0] ls_rdata_o,
   output logic        ls_valid_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o,
   output logic        if_err_o,
   output logic        ls_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

   state_t state, state_nxt;
   logic   owner_ls;     // 1: LS owns the bus, 0: IF owns it
   logic   discard;      // a flush hit the in-flight fetch
   logic   err_q;        // transaction ended by timeout
   logic   complete;     // bus response accepted this cycle
   logic   timeout;
   logic   busy;

   assign busy     = (state == REQ) || (state == WAIT);
   assign complete = ((state == REQ)  && bus_gnt_i && bus_rvalid_i) ||
                     ((state == WAIT) && bus_rvalid_i);

`ifdef ARB_TIMEOUT_EN
   logic [7:0] to_cnt;

   // The counter is 0 in the first REQ cycle. It fires on the last of
   // TO_LIM busy cycles, so RESP follows exactly TO_LIM cycles in REQ/WAIT.
   assign timeout = busy && !complete && (to_cnt == 8'(TO_LIM - 8'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt <= '0;
      else if (busy)
         to_cnt <= to_cnt + 8'd1;
      else
         to_cnt <= '0;
   end
`else
   logic unused_cfg;
   assign timeout    = 1'b0;
   assign unused_cfg = ^TO_LIM;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ls_req_i || if_req_i) state_nxt = REQ;
         REQ: begin
            if (complete || timeout) state_nxt = RESP;
            else if (bus_gnt_i)      state_nxt = WAIT;
         end
         WAIT: if (complete || timeout) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus payload, ownership, response capture and flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_ls    <= 1'b0;
         discard     <= 1'b0;
         err_q       <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_sel_o   <= '0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         if_rdata_o  <= '0;
         ls_rdata_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               discard <= 1'b0;
               err_q   <= 1'b0;
               if (ls_req_i) begin
                  owner_ls    <= 1'b1;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= ls_we_i;
                  bus_sel_o   <= ls_sel_i;
                  bus_addr_o  <= ls_addr_i;
                  bus_wdata_o <= ls_wdata_i;
               end else if (if_req_i) begin
                  owner_ls    <= 1'b0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_sel_o   <= 4'hF;
                  bus_addr_o  <= if_addr_i;
                  bus_wdata_o <= '0;
               end
            end
            REQ:  if (bus_gnt_i || timeout) bus_req_o <= 1'b0;
            WAIT: if (timeout) bus_req_o <= 1'b0;
            RESP: discard <= 1'b0;
            default: ;
         endcase

         if (busy && !owner_ls && flush_i)
            discard <= 1'b1;

         if (timeout)
            err_q <= 1'b1;

         // A discarded fetch must not disturb if_rdata_o. A flush that lands
         // in the completion cycle itself also counts as a discard.
         if (complete || timeout) begin
            if (owner_ls)
               ls_rdata_o <= timeout ? '0 : bus_rdata_i;
            else if (!discard && !flush_i)
               if_rdata_o <= timeout ? '0 : bus_rdata_i;
         end
      end
   end

   // Output logic. The stall requests are gated by rst so that every
   // output reads 0 while reset is held.
   always_comb begin
      if_valid_o     = (state == RESP) && !owner_ls && !discard;
      ls_valid_o     = (state == RESP) &&  owner_ls;
      if_err_o       = if_valid_o && err_q;
      ls_err_o       = ls_valid_o && err_q;
      stallreq_if_o  = rst && if_req_i && !if_valid_o;
      stallreq_mem_o = rst && ls_req_i && !ls_valid_o;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed self-checking bench for mem_bus_arbiter. Inputs are driven and
//   outputs are sampled on the falling clock edge. The DUT is built with
//   TIMEOUT_CYC=8, and the timeout step only runs when ARB_TIMEOUT_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, flush_i, ls_req_i, ls_we_i;
   logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, bus_rdata_i;
   logic [3:0]  ls_sel_i;
   logic        bus_gnt_i, bus_rvalid_i;
   logic [31:0] if_rdata_o, ls_rdata_o, bus_addr_o, bus_wdata_o;
   logic        if_valid_o, ls_valid_o, bus_req_o, bus_we_o;
   logic [3:0]  bus_sel_o;
   logic        stallreq_if_o, stallreq_mem_o, if_err_o, ls_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
      .flush_i(flush_i),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_sel_i(ls_sel_i),
      .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
      .ls_rdata_o(ls_rdata_o), .ls_valid_o(ls_valid_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i(bus_rdata_i),
      .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
      .if_err_o(if_err_o), .ls_err_o(ls_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " bus_req"},   32'(bus_req_o),      32'd0);
      chk({tag, " bus_addr"},  bus_addr_o,          32'd0);
      chk({tag, " bus_sel"},   32'(bus_sel_o),      32'd0);
      chk({tag, " ls_rdata"},  ls_rdata_o,          32'd0);
      chk({tag, " if_rdata"},  if_rdata_o,          32'd0);
      chk({tag, " ls_valid"},  32'(ls_valid_o),     32'd0);
      chk({tag, " if_valid"},  32'(if_valid_o),     32'd0);
      chk({tag, " stall_if"},  32'(stallreq_if_o),  32'd0);
      chk({tag, " stall_mem"}, 32'(stallreq_mem_o), 32'd0);
   endtask

   task automatic idle_bus();
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
      ls_req_i = 1'b0; ls_we_i = 1'b0; ls_sel_i = '0;
      ls_addr_i = '0; ls_wdata_i = '0;
      idle_bus();

      // Reset state
      nedge(); nedge();
      all_zero("reset");
      chk("reset if_err", 32'(if_err_o), 32'd0);
      rst = 1'b1;
      nedge();

      // Single fetch with the minimum 3-cycle latency
      if_req_i = 1'b1; if_addr_i = 32'h100;
      nedge();
      chk("f1 bus_req",   32'(bus_req_o), 32'd1);
      chk("f1 bus_addr",  bus_addr_o,     32'h100);
      chk("f1 bus_we",    32'(bus_we_o),  32'd0);
      chk("f1 bus_sel",   32'(bus_sel_o), 32'hF);
      chk("f1 bus_wdata", bus_wdata_o,    32'd0);
      chk("f1 stall_if",  32'(stallreq_if_o), 32'd1);
      bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
      nedge();
      chk("f1 if_valid", 32'(if_valid_o), 32'd1);
      chk("f1 if_rdata", if_rdata_o, 32'hDEADBEEF);
      chk("f1 if_err",   32'(if_err_o), 32'd0);
      chk("f1 stall_if resp", 32'(stallreq_if_o), 32'd0);
      chk("f1 bus_req resp",  32'(bus_req_o), 32'd0);
      if_req_i = 1'b0; idle_bus();
      nedge();
      chk("f1 valid pulse end", 32'(if_valid_o), 32'd0);
      chk("f1 rdata hold", if_rdata_o, 32'hDEADBEEF);

      // Simultaneous requests: LS first, IF after one IDLE cycle
      if_req_i = 1'b1; if_addr_i = 32'h200;
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_sel_i = 4'hF; ls_addr_i = 32'h300;
      nedge();
      chk("arb bus_addr ls", bus_addr_o, 32'h300);
      chk("arb bus_req",     32'(bus_req_o), 32'd1);
      chk("arb stall_if 1",  32'(stallreq_if_o), 32'd1);
      chk("arb stall_mem 1", 32'(stallreq_mem_o), 32'd1);
      bus_gnt_i = 1'b1;
      nedge();
      chk("arb bus_req wait", 32'(bus_req_o), 32'd0);
      chk("arb stall_if 2",   32'(stallreq_if_o), 32'd1);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hAAAA5555;
      nedge();
      chk("arb ls_valid",  32'(ls_valid_o), 32'd1);
      chk("arb ls_rdata",  ls_rdata_o, 32'hAAAA5555);
      chk("arb ls_err",    32'(ls_err_o), 32'd0);
      chk("arb if_valid",  32'(if_valid_o), 32'd0);
      chk("arb stall_mem resp", 32'(stallreq_mem_o), 32'd0);
      chk("arb stall_if 3", 32'(stallreq_if_o), 32'd1);
      ls_req_i = 1'b0; idle_bus();
      nedge();
      chk("arb idle bus_req", 32'(bus_req_o), 32'd0);
      chk("arb stall_if 4",   32'(stallreq_if_o), 32'd1);
      nedge();
      chk("arb if bus_req",  32'(bus_req_o), 32'd1);
      chk("arb if bus_addr", bus_addr_o, 32'h200);
      chk("arb if bus_sel",  32'(bus_sel_o), 32'hF);
      chk("arb stall_if 5",  32'(stallreq_if_o), 32'd1);
      bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11112222;
      nedge();
      chk("arb if_valid 2", 32'(if_valid_o), 32'd1);
      chk("arb if_rdata",   if_rdata_o, 32'h11112222);
      if_req_i = 1'b0; idle_bus();
      nedge();

      // Store with grant held off for 4 cycles
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_sel_i = 4'b0011;
      ls_addr_i = 32'h400; ls_wdata_i = 32'h1234;
      for (int i = 0; i < 4; i++) begin
         nedge();
         chk("st bus_req held", 32'(bus_req_o), 32'd1);
         chk("st bus_we",       32'(bus_we_o),  32'd1);
         chk("st bus_sel",      32'(bus_sel_o), 32'h3);
         chk("st bus_wdata",    bus_wdata_o,    32'h1234);
         chk("st ls_valid",     32'(ls_valid_o), 32'd0);
      end
      bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
      nedge();
      chk("st ls_valid", 32'(ls_valid_o), 32'd1);
      chk("st ls_rdata", ls_rdata_o, 32'hCAFEF00D);
      chk("st bus_req",  32'(bus_req_o), 32'd0);
      ls_req_i = 1'b0; ls_we_i = 1'b0; idle_bus();
      nedge();
      chk("st ls_valid end", 32'(ls_valid_o), 32'd0);
      chk("st rdata hold",   ls_rdata_o, 32'hCAFEF00D);

      // Flush during WAIT suppresses the fetch result
      if_req_i = 1'b1; if_addr_i = 32'h500;
      nedge();
      bus_gnt_i = 1'b1;
      nedge();
      bus_gnt_i = 1'b0; flush_i = 1'b1;
      nedge();
      flush_i = 1'b0;
      chk("fl bus_req", 32'(bus_req_o), 32'd0);
      nedge();
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h00000055;
      nedge();
      chk("fl if_valid",    32'(if_valid_o), 32'd0);
      chk("fl rdata hold",  if_rdata_o, 32'h11112222);
      chk("fl stall_if",    32'(stallreq_if_o), 32'd1);
      if_req_i = 1'b0; idle_bus();
      nedge();
      chk("fl idle valid", 32'(if_valid_o), 32'd0);
      // A fresh fetch proves the FSM is back in IDLE and the discard is gone
      if_req_i = 1'b1; if_addr_i = 32'h600;
      nedge();
      chk("fl next bus_req",  32'(bus_req_o), 32'd1);
      chk("fl next bus_addr", bus_addr_o, 32'h600);
      bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h66;
      nedge();
      chk("fl next if_valid", 32'(if_valid_o), 32'd1);
      chk("fl next if_rdata", if_rdata_o, 32'h66);
      if_req_i = 1'b0; idle_bus();
      nedge();

      // Reset asserted while in WAIT
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_sel_i = 4'hF; ls_addr_i = 32'h700;
      nedge();
      bus_gnt_i = 1'b1;
      nedge();
      bus_gnt_i = 1'b0;
      #1 rst = 1'b0;
      #1 all_zero("rst wait");
      nedge();
      rst = 1'b1; ls_req_i = 1'b0;
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77;
      for (int i = 0; i < 2; i++) begin
         nedge();
         chk("rst late ls_valid", 32'(ls_valid_o), 32'd0);
         chk("rst late bus_req",  32'(bus_req_o), 32'd0);
         chk("rst late ls_rdata", ls_rdata_o, 32'd0);
      end
      idle_bus();
      nedge();

`ifdef ARB_TIMEOUT_EN
      // Timeout: the grant never arrives
      ls_req_i = 1'b1; ls_addr_i = 32'h800;
      for (int i = 0; i < 8; i++) begin
         nedge();
         chk("to pending valid", 32'(ls_valid_o), 32'd0);
         chk("to bus_req",       32'(bus_req_o), 32'd1);
      end
      nedge();
      chk("to ls_valid", 32'(ls_valid_o), 32'd1);
      chk("to ls_err",   32'(ls_err_o),   32'd1);
      chk("to ls_rdata", ls_rdata_o,      32'd0);
      chk("to bus_req",  32'(bus_req_o),  32'd0);
      ls_req_i = 1'b0;
      nedge();
      chk("to err end", 32'(ls_err_o), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: bus-timeout limit in cycles, 8-bit, used only when ARB_TIMEOUT_EN is defined.
REQ-002 Clock clk; reset rst, asynchronous, active-low.
REQ-003 clk  input  1  core clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 if_req_i  input  1  fetch read request, held until if_valid_o.
REQ-006 if_addr_i  input  32  fetch address.
REQ-007 if_rdata_o  output  32  fetch read data, valid with if_valid_o.
REQ-008 if_valid_o  output  1  one-cycle fetch completion pulse.
REQ-009 flush_i  input  1  pipeline flush, discards an in-flight fetch result.
REQ-010 ls_req_i / ls_we_i  input  1 / 1  load-store request (held until ls_valid_o) / write enable.
REQ-011 ls_sel_i  input  4  byte lanes.
REQ-012 ls_addr_i / ls_wdata_i  input  32 / 32  load-store address / write data.
REQ-013 ls_rdata_o / ls_valid_o  output  32 / 1  load data / one-cycle load-store completion pulse.
REQ-014 bus_req_o, bus_we_o, bus_sel_o[3:0], bus_addr_o[31:0], bus_wdata_o[31:0]  output  shared-bus request and payload, all registered.
REQ-015 bus_gnt_i / bus_rvalid_i / bus_rdata_i[31:0]  input  bus grant / response valid / read data.
REQ-016 stallreq_if_o / stallreq_mem_o  output  1 / 1  stall requests into the pipeline stall vector.
REQ-017 if_err_o / ls_err_o  output  1 / 1  timeout error, pulsed with the matching valid.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; one transaction in flight at a time; owner register selects IF or LS.
REQ-019 IDLE: ls_req_i takes priority over if_req_i; the winner's payload is latched into the bus_* registers, owner recorded, next state REQ; no request -> stay IDLE.
REQ-020 Fetch transactions drive bus_we_o=0, bus_sel_o=4'hF, bus_wdata_o=0.
REQ-021 REQ: bus_req_o=1; bus_gnt_i=1 -> WAIT with bus_req_o=0 next cycle; bus_gnt_i and bus_rvalid_i both high in the same cycle -> RESP directly.
REQ-022 WAIT: bus_rvalid_i=1 -> capture bus_rdata_i into the owner's rdata register, next state RESP.
REQ-023 RESP: owner's valid asserted for exactly this one cycle; next state IDLE, so one idle arbitration cycle always separates transactions.
REQ-024 Minimum latency request-to-valid is 3 cycles (IDLE, REQ with gnt and rvalid, RESP).
REQ-025 Writes complete on bus_rvalid_i exactly as reads; ls_rdata_o takes bus_rdata_i regardless of ls_we_i.
REQ-026 rdata outputs hold their last value between valid pulses.
REQ-027 stallreq_mem_o = ls_req_i and not ls_valid_o, combinational.
REQ-028 stallreq_if_o = if_req_i and not if_valid_o, combinational.
REQ-029 flush_i high in any cycle while owner=IF in REQ or WAIT sets a discard flag; the bus transaction completes normally, but if_valid_o stays 0 in RESP; the flag clears on entering IDLE.
REQ-030 flush_i in IDLE or RESP has no effect; flush_i never aborts an LS transaction.
REQ-031 A request dropped mid-transaction does not abort the transaction; the response is delivered and ignored by the requester.

Reset
REQ-032 On rst low all outputs SHALL reset asynchronously to 0, the FSM to IDLE, the discard flag and timeout counter to 0.
REQ-033 Reset mid-transaction abandons the transaction; no valid pulse for it after release.

Configuration
REQ-034 Macro ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
REQ-035 With ARB_TIMEOUT_EN, counter reaching TIMEOUT_CYC with no completion -> bus_req_o=0, RESP with owner valid=1, owner err=1, owner rdata=0; the flush discard rule also suppresses if_err_o.
REQ-036 Without ARB_TIMEOUT_EN: no counter; transactions wait indefinitely; if_err_o and ls_err_o tied 0.

Verification
REQ-037 if_req_i=1, addr 0x100, gnt and rvalid both high in the first REQ cycle with rdata 0xDEADBEEF -> if_valid_o pulses at cycle 3 with if_rdata_o=0xDEADBEEF.
REQ-038 if_req_i and ls_req_i asserted together -> LS served first (bus_addr_o=ls_addr_i); the IF transaction starts after one IDLE cycle; stallreq_if_o stays high throughout.
REQ-039 Store: ls_we_i=1, sel 4'b0011, wdata 0x1234 -> bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0x1234; gnt delayed 4 cycles, so bus_req_o is held 4 cycles.
REQ-040 Fetch in WAIT with flush_i pulsed for one cycle, then rvalid -> no if_valid_o; FSM returns to IDLE.
REQ-041 rst driven low while in WAIT -> all outputs 0 immediately; a later rvalid produces no valid pulse.
REQ-042 With ARB_TIMEOUT_EN and TIMEOUT_CYC=8, gnt never asserted -> after 8 cycles ls_valid_o=1, ls_err_o=1, ls_rdata_o=0.
